// File: rtl/mvm_pkg.sv
// ---------------------------------------------------------------------------
// mvm_pkg
// Shared definitions for the matrix-vector row scheduler:
//   - sched_state_t  : scheduler FSM states
//   - mac_tag_t      : per-MAC-cycle tag fed into the accumulator control pipe
//   - M_DEFAULT / N_DEFAULT : default layer geometry (rows, vector length)
//   - ACC_PIPE_DEPTH : read latency (1) plus product register (1)
// ---------------------------------------------------------------------------
package mvm_pkg;

    localparam int unsigned M_DEFAULT      = 16;
    localparam int unsigned N_DEFAULT      = 8;
    localparam int unsigned ACC_PIPE_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } sched_state_t;

    // Tag describing the MAC cycle whose addresses are presented this cycle.
    typedef struct packed {
        logic first;  // MAC cycle 0 of a row (bias address valid)
        logic mac;    // any MAC cycle (one product will arrive)
        logic last;   // MAC cycle N-1 (final product of the row)
    } mac_tag_t;

endpackage

// File: rtl/mvm_acc_pipe.sv
// ---------------------------------------------------------------------------
// mvm_acc_pipe
// Delays the MAC-cycle tags so the accumulator strobes line up with the data
// returning from the memories. The bias arrives after the 1-cycle ROM read,
// each product after the read plus the product register (ACC_PIPE_DEPTH).
//
// Optional feature: define MVM_SCHED_RELU_EN to drive o_relu_en together with
// the final accumulate of a row; otherwise o_relu_en is tied low.
//
// Ports:
//   i_clk       clock
//   i_reset     asynchronous active-high reset
//   i_tag       MAC-cycle tag from the scheduler FSM
//   o_acc_load  load bias into accumulator (1 cycle after MAC cycle 0)
//   o_acc_en    add product into accumulator (2 cycles after each MAC cycle)
//   o_relu_en   clamp negative result, coincident with the last o_acc_en
// ---------------------------------------------------------------------------
module mvm_acc_pipe
    import mvm_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  mac_tag_t i_tag,
    output logic     o_acc_load,
    output logic     o_acc_en,
    output logic     o_relu_en
);

`ifdef MVM_SCHED_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic                      r_load;
    logic [ACC_PIPE_DEPTH-1:0] r_mac_sr;
    logic [ACC_PIPE_DEPTH-1:0] r_last_sr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_load    <= 1'b0;
            r_mac_sr  <= '0;
            r_last_sr <= '0;
        end else begin
            r_load    <= i_tag.first;
            r_mac_sr  <= {r_mac_sr[ACC_PIPE_DEPTH-2:0], i_tag.mac};
            r_last_sr <= {r_last_sr[ACC_PIPE_DEPTH-2:0], i_tag.last};
        end
    end

    assign o_acc_load = r_load;
    assign o_acc_en   = r_mac_sr[ACC_PIPE_DEPTH-1];
    assign o_relu_en  = RELU_ON & r_last_sr[ACC_PIPE_DEPTH-1];

endmodule

// File: rtl/mvm_row_scheduler.sv
// ---------------------------------------------------------------------------
// mvm_row_scheduler
// Control for a row-serial matrix-vector multiply: loads the N-word input
// vector into x-memory, then for each of M output rows sweeps N MAC cycles
// over x-memory and the weight ROM, drains the accumulator pipeline and
// presents the row result with a valid/ready handshake. After the last row
// the next input vector is loaded.
//
// Optional feature: MVM_SCHED_RELU_EN (see mvm_acc_pipe) enables relu_en.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   s_valid / s_ready upstream input-word handshake (LOAD only)
//   m_valid / m_ready row-result handshake (OUT only)
//   wr_en_x           x-memory write strobe (s_valid & s_ready)
//   addr_x            x-memory address (write in LOAD, read in MAC)
//   addr_w            weight ROM address, row_idx*N + j in MAC
//   addr_b            bias ROM address (current row)
//   acc_load, acc_en  accumulator bias-load / product-add strobes
//   relu_en           clamp-negative strobe on the final add
//   row_idx           current output row
// ---------------------------------------------------------------------------
module mvm_row_scheduler
    import mvm_pkg::*;
#(
    parameter int unsigned M = M_DEFAULT,
    parameter int unsigned N = N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   m_ready,
    output logic                   m_valid,
    output logic                   wr_en_x,
    output logic [$clog2(N)-1:0]   addr_x,
    output logic [$clog2(M*N)-1:0] addr_w,
    output logic [$clog2(M)-1:0]   addr_b,
    output logic                   acc_load,
    output logic                   acc_en,
    output logic                   relu_en,
    output logic [$clog2(M)-1:0]   row_idx
);

    localparam int unsigned XW = $clog2(N);
    localparam int unsigned WW = $clog2(M*N);
    localparam int unsigned BW = $clog2(M);

    localparam logic [XW-1:0] CNT_LAST   = XW'(N - 1);
    localparam logic [XW-1:0] DRAIN_LAST = XW'(ACC_PIPE_DEPTH - 1);
    localparam logic [BW-1:0] ROW_LAST   = BW'(M - 1);
    localparam logic [WW-1:0] W_STRIDE   = WW'(N);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    // Shared counter: word index in LOAD, MAC cycle j in MAC, drain cycle in DRAIN.
    logic [XW-1:0] r_cnt;
    logic [XW-1:0] w_cnt_nxt;
    logic [BW-1:0] r_row;
    logic [BW-1:0] w_row_nxt;
    // Base weight address of the current row (row_idx*N), kept incrementally.
    logic [WW-1:0] r_wbase;
    logic [WW-1:0] w_wbase_nxt;
    mac_tag_t      w_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_wbase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_wbase <= w_wbase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_wbase_nxt = r_wbase;
        w_tag       = '0;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        wr_en_x     = 1'b0;
        addr_x      = '0;
        addr_w      = r_wbase;

        unique case (r_state)
            IDLE: begin
                w_state_nxt = LOAD;
            end

            LOAD: begin
                s_ready = 1'b1;
                wr_en_x = s_valid;
                addr_x  = r_cnt;
                if (s_valid) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_row_nxt   = '0;
                        w_wbase_nxt = '0;
                        w_state_nxt = MAC;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            MAC: begin
                addr_x     = r_cnt;
                addr_w     = r_wbase + WW'(r_cnt);
                w_tag.mac   = 1'b1;
                w_tag.first = (r_cnt == '0);
                w_tag.last  = (r_cnt == CNT_LAST);
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            // Wait for the last product to clear the read + product registers.
            DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = OUT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (r_row == ROW_LAST) begin
                        w_row_nxt   = '0;
                        w_wbase_nxt = '0;
                        w_state_nxt = LOAD;
                    end else begin
                        w_row_nxt   = r_row + 1'b1;
                        w_wbase_nxt = r_wbase + W_STRIDE;
                        w_state_nxt = MAC;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign addr_b  = r_row;
    assign row_idx = r_row;

    mvm_acc_pipe u_acc_pipe (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_tag      (w_tag),
        .o_acc_load (acc_load),
        .o_acc_en   (acc_en),
        .o_relu_en  (relu_en)
    );

endmodule
